// File: rtl/mpi_rndv_recv_ctrl_if.sv
// Bundle of request, network rx, control tx and payload streams for the rendezvous receiver.
// No logic; pure signal grouping.
// slave = receiver block view, master = environment (network/kernel) view.
interface mpi_rndv_recv_ctrl_if;
    logic        recv_req_valid;
    logic        recv_req_ready;
    logic [7:0]  recv_req_src;
    logic [15:0] recv_req_size;

    logic [63:0] s_in_data;
    logic [7:0]  s_in_keep;
    logic        s_in_last;
    logic        s_in_valid;
    logic        s_in_ready;

    logic [63:0] m_out_data;
    logic [7:0]  m_out_keep;
    logic        m_out_last;
    logic        m_out_valid;
    logic        m_out_ready;

    logic [63:0] m_data_data;
    logic [7:0]  m_data_keep;
    logic        m_data_last;
    logic        m_data_valid;
    logic        m_data_ready;

    logic        recv_done;
    logic        recv_err;
    logic [15:0] drop_cnt;

    modport slave (
        input  recv_req_valid, recv_req_src, recv_req_size,
        output recv_req_ready,
        input  s_in_data, s_in_keep, s_in_last, s_in_valid,
        output s_in_ready,
        output m_out_data, m_out_keep, m_out_last, m_out_valid,
        input  m_out_ready,
        output m_data_data, m_data_keep, m_data_last, m_data_valid,
        input  m_data_ready,
        output recv_done, recv_err, drop_cnt
    );

    modport master (
        output recv_req_valid, recv_req_src, recv_req_size,
        input  recv_req_ready,
        output s_in_data, s_in_keep, s_in_last, s_in_valid,
        input  s_in_ready,
        input  m_out_data, m_out_keep, m_out_last, m_out_valid,
        output m_out_ready,
        input  m_data_data, m_data_keep, m_data_last, m_data_valid,
        output m_data_ready,
        input  recv_done, recv_err, drop_cnt
    );
endinterface

// File: rtl/mpi_rndv_recv_ctrl.sv
// MPI rendezvous receive responder: SYNC envelope -> CTS -> DATA stream -> DONE.
// Latency: CTS/DONE valid one cycle after the triggering last beat; payload is a zero-latency pass-through.
// Backpressure: s_in stalled while a control word is pending; payload ready follows m_data_ready.
module mpi_rndv_recv_ctrl #(
    parameter logic [15:0] MY_RANK = 16'd0
) (
    input  logic          clk,
    input  logic          rst,
    mpi_rndv_recv_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, WAIT_ENV, SKIP_ENV, SEND_CTS, WAIT_DATA, STREAM, SEND_DONE, DISCARD
    } state_t;

    localparam logic [7:0] T_SYNC = 8'd0;
    localparam logic [7:0] T_DATA = 8'd2;

    state_t      state_q, state_d, ret_q, ret_d;
    logic [7:0]  exp_src_q;
    logic [15:0] exp_size_q;
    logic [7:0]  tag_q;
    logic [17:0] bytecnt_q;
    logic [15:0] drop_cnt_q;
    logic        recv_done_q, recv_err_q;

    // header field decode of the current s_in beat
    logic [7:0]  hdr_tag, hdr_type, hdr_src;
    logic [15:0] hdr_size, hdr_dst;
    assign hdr_tag  = bus.s_in_data[55:48];
    assign hdr_size = bus.s_in_data[47:32];
    assign hdr_type = bus.s_in_data[31:24];
    assign hdr_src  = bus.s_in_data[23:16];
    assign hdr_dst  = bus.s_in_data[15:0];

    logic env_match, data_match;
    assign env_match  = (hdr_type == T_SYNC) && (hdr_src == exp_src_q) && (hdr_dst == MY_RANK);
    assign data_match = (hdr_type == T_DATA) && (hdr_src == exp_src_q) && (hdr_dst == MY_RANK);

    function automatic logic [3:0] popcnt8(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
        return c;
    endfunction

    logic [17:0] exp_bytes, bytecnt_sum;
    assign exp_bytes   = {exp_size_q, 2'b00};
    assign bytecnt_sum = bytecnt_q + {14'd0, popcnt8(bus.s_in_keep)};

    logic        in_rdy, out_vld, dat_vld;
    logic [63:0] out_dat;
    logic        in_beat;
    assign in_beat = bus.s_in_valid && in_rdy;

    // state register, including the return state used after DISCARD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ret_q   <= WAIT_ENV;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            IDLE:      if (bus.recv_req_valid) state_d = WAIT_ENV;
            WAIT_ENV:  if (bus.s_in_valid) begin
                           if (env_match)           state_d = bus.s_in_last ? SEND_CTS : SKIP_ENV;
                           else if (!bus.s_in_last) begin state_d = DISCARD; ret_d = WAIT_ENV; end
                       end
            SKIP_ENV:  if (bus.s_in_valid && bus.s_in_last) state_d = SEND_CTS;
            SEND_CTS:  if (bus.m_out_ready) state_d = WAIT_DATA;
            WAIT_DATA: if (bus.s_in_valid) begin
                           if (data_match)          state_d = bus.s_in_last ? SEND_DONE : STREAM;
                           else if (!bus.s_in_last) begin state_d = DISCARD; ret_d = WAIT_DATA; end
                       end
            STREAM:    if (in_beat && bus.s_in_last) state_d = SEND_DONE;
            SEND_DONE: if (bus.m_out_ready) state_d = IDLE;
            DISCARD:   if (bus.s_in_valid && bus.s_in_last) state_d = ret_q;
            default:   state_d = IDLE;
        endcase
    end

    // outputs decoded from state; STREAM forwards s_in straight to m_data
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        dat_vld = 1'b0;
        out_dat = {8'd1, tag_q, exp_size_q, 8'd1, MY_RANK[7:0], 8'd0, exp_src_q};
        case (state_q)
            WAIT_ENV, SKIP_ENV, WAIT_DATA, DISCARD: in_rdy = 1'b1;
            SEND_CTS:  out_vld = 1'b1;
            STREAM: begin
                in_rdy  = bus.m_data_ready;
                dat_vld = bus.s_in_valid;
            end
            SEND_DONE: begin
                out_vld = 1'b1;
                out_dat = {8'd1, 8'd0, 16'd0, 8'd5, MY_RANK[7:0], 8'd0, exp_src_q};
            end
            default: ;
        endcase
    end

    // request latch, tag capture, byte counting, drop counter and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_src_q   <= 8'd0;
            exp_size_q  <= 16'd0;
            tag_q       <= 8'd0;
            bytecnt_q   <= 18'd0;
            drop_cnt_q  <= 16'd0;
            recv_done_q <= 1'b0;
            recv_err_q  <= 1'b0;
        end else begin
            recv_done_q <= (state_q == SEND_DONE) && bus.m_out_ready;
            recv_err_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.recv_req_valid) begin
                    exp_src_q  <= bus.recv_req_src;
                    exp_size_q <= bus.recv_req_size;
                end
                WAIT_ENV: if (bus.s_in_valid) begin
                    if (env_match)                   tag_q      <= hdr_tag;
                    else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                end
                WAIT_DATA: if (bus.s_in_valid) begin
                    if (data_match) begin
                        bytecnt_q  <= 18'd0;
                        recv_err_q <= ({2'b00, hdr_size} != exp_bytes);
                    end else if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                end
                STREAM: if (in_beat) begin
                    bytecnt_q <= bytecnt_sum;
                    if (bus.s_in_last) recv_err_q <= (bytecnt_sum != exp_bytes);
                end
                default: ;
            endcase
        end
    end

    assign bus.recv_req_ready = (state_q == IDLE);
    assign bus.s_in_ready     = in_rdy;
    assign bus.m_out_data     = out_dat;
    assign bus.m_out_keep     = 8'hFF;
    assign bus.m_out_last     = 1'b1;
    assign bus.m_out_valid    = out_vld;
    assign bus.m_data_data    = bus.s_in_data;
    assign bus.m_data_keep    = bus.s_in_keep;
    assign bus.m_data_last    = bus.s_in_last;
    assign bus.m_data_valid   = dat_vld;
    assign bus.recv_done      = recv_done_q;
    assign bus.recv_err       = recv_err_q;
    assign bus.drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_mpi_rndv_recv_ctrl.sv
// Directed bench for the rendezvous receiver: envelope match/drop, CTS hold, payload flow, errors, reset abort.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
// m_out/m_data backpressure controlled by the bench (m_data_ready optionally toggling).
module tb_mpi_rndv_recv_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpi_rndv_recv_ctrl_if bus();

    mpi_rndv_recv_ctrl #(.MY_RANK(16'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // capture of transferred beats and status pulses (only writer of these)
    logic [63:0] mo_dat [256];
    logic [8:0]  mo_kl  [256];
    logic [63:0] md_dat [256];
    logic [8:0]  md_kl  [256];
    int mo_n = 0, md_n = 0, done_cnt = 0, err_cnt = 0;
    int mo_rd = 0, md_rd = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_out_valid && bus.m_out_ready) begin
                mo_dat[mo_n[7:0]] = bus.m_out_data;
                mo_kl[mo_n[7:0]]  = {bus.m_out_keep, bus.m_out_last};
                mo_n++;
            end
            if (bus.m_data_valid && bus.m_data_ready) begin
                md_dat[md_n[7:0]] = bus.m_data_data;
                md_kl[md_n[7:0]]  = {bus.m_data_keep, bus.m_data_last};
                md_n++;
            end
            if (bus.recv_done) done_cnt++;
            if (bus.recv_err)  err_cnt++;
        end
    end

    // m_data_ready: constant 1, or toggling each cycle when tog_en is set
    logic tog_en = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.m_data_ready = tog_en ? ~bus.m_data_ready : 1'b1;
    end

    function automatic logic [63:0] hdr(input logic [7:0] tag, input logic [15:0] size,
                                        input logic [7:0] typ, input logic [7:0] src,
                                        input logic [15:0] dst);
        return {8'd1, tag, size, typ, src, dst};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [7:0] src, input logic [15:0] size);
        int n;
        bus.recv_req_valid = 1'b1;
        bus.recv_req_src   = src;
        bus.recv_req_size  = size;
        n = 0;
        @(negedge clk);
        while (!bus.recv_req_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.recv_req_ready) chk("req_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.recv_req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        bus.s_in_data  = d;
        bus.s_in_keep  = k;
        bus.s_in_last  = l;
        bus.s_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_in_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.s_in_ready) chk("s_in_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.s_in_valid = 1'b0;
    endtask

    task automatic pop_mo(input string name, input logic [63:0] exp);
        if (mo_rd < mo_n) begin
            chk(name, mo_dat[mo_rd[7:0]], exp);
            chk({name, "_keeplast"}, {55'd0, mo_kl[mo_rd[7:0]]}, 64'h1FF);
            mo_rd++;
        end else begin
            chk({name, "_present"}, 64'd0, 64'd1);
        end
    endtask

    task automatic pop_md(input string name, input logic [63:0] exp, input logic [8:0] kl);
        if (md_rd < md_n) begin
            chk(name, md_dat[md_rd[7:0]], exp);
            chk({name, "_keeplast"}, {55'd0, md_kl[md_rd[7:0]]}, {55'd0, kl});
            md_rd++;
        end else begin
            chk({name, "_present"}, 64'd0, 64'd1);
        end
    endtask

    int d0, e0, hold_bad;

    initial begin
        bus.recv_req_valid = 1'b0;
        bus.recv_req_src   = 8'd0;
        bus.recv_req_size  = 16'd0;
        bus.s_in_data      = 64'd0;
        bus.s_in_keep      = 8'd0;
        bus.s_in_last      = 1'b0;
        bus.s_in_valid     = 1'b0;
        bus.m_out_ready    = 1'b1;

        // reset state
        wait_cyc(3);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, bus.recv_req_ready}, 64'd1);
        chk("rst_s_in_ready", {63'd0, bus.s_in_ready}, 64'd0);
        chk("rst_m_out_valid", {63'd0, bus.m_out_valid}, 64'd0);
        chk("rst_m_data_valid", {63'd0, bus.m_data_valid}, 64'd0);
        chk("rst_pulses", {62'd0, bus.recv_done, bus.recv_err}, 64'd0);
        chk("rst_drop_cnt", {48'd0, bus.drop_cnt}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cyc(1);

        // 1: basic exchange, src=3 size=4 words
        d0 = done_cnt; e0 = err_cnt;
        do_req(8'd3, 16'd4);
        send_beat(hdr(8'h00, 16'd0, 8'd0, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'hDEAD_BEEF_0000_0000, 8'hFF, 1'b1);
        wait_cyc(3);
        pop_mo("t1_cts", 64'h0100_0004_0100_0003);
        send_beat(hdr(8'h00, 16'd16, 8'd2, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b1);
        wait_cyc(4);
        pop_md("t1_pay0", 64'h1111_1111_1111_1111, 9'h1FE);
        pop_md("t1_pay1", 64'h2222_2222_2222_2222, 9'h1FF);
        pop_mo("t1_done", 64'h0100_0000_0500_0003);
        chk("t1_recv_done", done_cnt - d0, 1);
        chk("t1_recv_err", err_cnt - e0, 0);
        chk("t1_idle", {63'd0, bus.recv_req_ready}, 64'd1);

        // 2: wrong-source envelope dropped, then a match; stray DATA dropped too
        d0 = done_cnt; e0 = err_cnt;
        do_req(8'd3, 16'd2);
        send_beat(hdr(8'h22, 16'd0, 8'd0, 8'd5, 16'd0), 8'hFF, 1'b0);
        send_beat(64'h0, 8'hFF, 1'b1);
        wait_cyc(3);
        chk("t2_drop1", {48'd0, bus.drop_cnt}, 64'd1);
        chk("t2_no_cts", mo_n - mo_rd, 0);
        send_beat(hdr(8'h22, 16'd0, 8'd0, 8'd3, 16'd0), 8'hFF, 1'b1);
        wait_cyc(2);
        pop_mo("t2_cts", 64'h0122_0002_0100_0003);
        send_beat(hdr(8'h22, 16'd8, 8'd2, 8'd4, 16'd0), 8'hFF, 1'b1);
        wait_cyc(1);
        chk("t2_drop2", {48'd0, bus.drop_cnt}, 64'd2);
        send_beat(hdr(8'h22, 16'd8, 8'd2, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'h3333_4444_5555_6666, 8'hFF, 1'b1);
        wait_cyc(4);
        pop_md("t2_pay0", 64'h3333_4444_5555_6666, 9'h1FF);
        pop_mo("t2_done", 64'h0100_0000_0500_0003);
        chk("t2_recv_done", done_cnt - d0, 1);
        chk("t2_recv_err", err_cnt - e0, 0);

        // 3: CTS held under backpressure, payload under toggling ready
        d0 = done_cnt; e0 = err_cnt;
        do_req(8'd3, 16'd6);
        bus.m_out_ready = 1'b0;
        send_beat(hdr(8'h33, 16'd0, 8'd0, 8'd3, 16'd0), 8'hFF, 1'b1);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.m_out_valid || bus.m_out_data !== 64'h0133_0006_0100_0003 || bus.s_in_ready)
                hold_bad++;
        end
        chk("t3_cts_hold", hold_bad, 0);
        chk("t3_no_early_cts", mo_n - mo_rd, 0);
        @(posedge clk); #1;
        bus.m_out_ready = 1'b1;
        wait_cyc(2);
        pop_mo("t3_cts", 64'h0133_0006_0100_0003);
        tog_en = 1'b1;
        send_beat(hdr(8'h33, 16'd24, 8'd2, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'hA000_0000_0000_000A, 8'hFF, 1'b0);
        send_beat(64'hB000_0000_0000_000B, 8'hFF, 1'b0);
        send_beat(64'hC000_0000_0000_000C, 8'hFF, 1'b1);
        wait_cyc(4);
        tog_en = 1'b0;
        pop_md("t3_pay0", 64'hA000_0000_0000_000A, 9'h1FE);
        pop_md("t3_pay1", 64'hB000_0000_0000_000B, 9'h1FE);
        pop_md("t3_pay2", 64'hC000_0000_0000_000C, 9'h1FF);
        pop_mo("t3_done", 64'h0100_0000_0500_0003);
        chk("t3_recv_done", done_cnt - d0, 1);
        chk("t3_recv_err", err_cnt - e0, 0);

        // 4: short last beat -> 12 bytes vs 16 expected -> error, DONE still sent
        d0 = done_cnt; e0 = err_cnt;
        do_req(8'd3, 16'd4);
        send_beat(hdr(8'h44, 16'd0, 8'd0, 8'd3, 16'd0), 8'hFF, 1'b1);
        wait_cyc(2);
        pop_mo("t4_cts", 64'h0144_0004_0100_0003);
        send_beat(hdr(8'h44, 16'd16, 8'd2, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'h7777_7777_7777_7777, 8'hFF, 1'b0);
        send_beat(64'h0000_0000_8888_8888, 8'h0F, 1'b1);
        wait_cyc(4);
        pop_md("t4_pay0", 64'h7777_7777_7777_7777, 9'h1FE);
        pop_md("t4_pay1", 64'h0000_0000_8888_8888, 9'h01F);
        pop_mo("t4_done", 64'h0100_0000_0500_0003);
        chk("t4_recv_err", err_cnt - e0, 1);
        chk("t4_recv_done", done_cnt - d0, 1);

        // 6: zero-length message, header-only DATA
        d0 = done_cnt; e0 = err_cnt;
        do_req(8'd7, 16'd0);
        send_beat(hdr(8'h66, 16'd0, 8'd0, 8'd7, 16'd0), 8'hFF, 1'b1);
        wait_cyc(2);
        pop_mo("t6_cts", 64'h0166_0000_0100_0007);
        send_beat(hdr(8'h66, 16'd0, 8'd2, 8'd7, 16'd0), 8'hFF, 1'b1);
        wait_cyc(4);
        pop_mo("t6_done", 64'h0100_0000_0500_0007);
        chk("t6_no_payload", md_n - md_rd, 0);
        chk("t6_recv_done", done_cnt - d0, 1);
        chk("t6_recv_err", err_cnt - e0, 0);

        // 5: reset in the middle of STREAM aborts, then a clean transfer
        d0 = done_cnt; e0 = err_cnt;
        do_req(8'd3, 16'd4);
        send_beat(hdr(8'h55, 16'd0, 8'd0, 8'd3, 16'd0), 8'hFF, 1'b1);
        wait_cyc(2);
        pop_mo("t5_cts", 64'h0155_0004_0100_0003);
        send_beat(hdr(8'h55, 16'd16, 8'd2, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'h9999_9999_9999_9999, 8'hFF, 1'b0);
        bus.s_in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_idle", {63'd0, bus.recv_req_ready}, 64'd1);
        chk("t5_rst_m_data_valid", {63'd0, bus.m_data_valid}, 64'd0);
        chk("t5_rst_m_out_valid", {63'd0, bus.m_out_valid}, 64'd0);
        chk("t5_rst_drop_cnt", {48'd0, bus.drop_cnt}, 64'd0);
        bus.s_in_valid = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(5);
        pop_md("t5_pay0", 64'h9999_9999_9999_9999, 9'h1FE);
        chk("t5_no_done_word", mo_n - mo_rd, 0);
        chk("t5_no_done_pulse", done_cnt - d0, 0);
        do_req(8'd3, 16'd4);
        send_beat(hdr(8'h5A, 16'd0, 8'd0, 8'd3, 16'd0), 8'hFF, 1'b1);
        wait_cyc(2);
        pop_mo("t5b_cts", 64'h015A_0004_0100_0003);
        send_beat(hdr(8'h5A, 16'd16, 8'd2, 8'd3, 16'd0), 8'hFF, 1'b0);
        send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        send_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
        wait_cyc(4);
        pop_md("t5b_pay0", 64'h0123_4567_89AB_CDEF, 9'h1FE);
        pop_md("t5b_pay1", 64'hFEDC_BA98_7654_3210, 9'h1FF);
        pop_mo("t5b_done", 64'h0100_0000_0500_0003);
        chk("t5b_recv_done", done_cnt - d0, 1);
        chk("t5b_recv_err", err_cnt - e0, 0);
        chk("end_no_extra_ctrl", mo_n - mo_rd, 0);
        chk("end_no_extra_payload", md_n - md_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
